hit_event_resolver: RTL and testbench

//  Consumer end of the collision path: takes the once-per-frame hit pulses from the collision controller
//  and applies their game consequences at the next frame boundary.

---
 rtl/hit_event_resolver_pkg.sv | 25 ++
 rtl/hit_event_resolver_frame_event_latch.sv | 51 +++++
 rtl/hit_event_resolver.sv | 164 ++++++++++++++++
 tb/tb_hit_event_resolver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hit_event_resolver_pkg.sv
// Shared types and default constants for the hit/event resolution path.
// Imported by the top and the per-source capture latch.
package hit_event_resolver_pkg;

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } hit_state_t;

   localparam int unsigned DEF_START_LIVES   = 3;
   localparam int unsigned DEF_LIVES_W       = 3;
   localparam int unsigned DEF_SCORE_W       = 14;
   localparam int unsigned DEF_ALIEN_POINTS  = 10;
   localparam int unsigned DEF_INVULN_FRAMES = 60;
   localparam int unsigned DEF_ID_W          = 6;

   // Invulnerability counter width; never below 3 so bit 2 exists for the blink output.
   function automatic int unsigned inv_cnt_width(input int unsigned frames);
      int unsigned w;
      w = $clog2(frames + 1);
      return (w < 3) ? 3 : w;
   endfunction

endpackage

// File: rtl/hit_event_resolver_frame_event_latch.sv
// Pulse-to-pending capture for one hit source. Keeps the first pulse of a frame; on the
// frame boundary the pending flag is consumed and any coinciding pulse re-arms it.
module hit_event_resolver_frame_event_latch
   import hit_event_resolver_pkg::*;
#(
   parameter int unsigned ID_W = DEF_ID_W
) (
   input  logic            clk,
   input  logic            resetN,
   input  logic            sof,
   input  logic            clr,
   input  logic            pulse,
   input  logic [ID_W-1:0] id,
   output logic            pend,
   output logic [ID_W-1:0] pend_id
);

   logic            pend_q, pend_d;
   logic [ID_W-1:0] id_q, id_d;

   always_comb begin
      pend_d = pend_q;
      id_d   = id_q;
      if (clr) begin
         pend_d = 1'b0;
         id_d   = '0;
      end else if (sof) begin
         pend_d = pulse;
         if (pulse) begin
            id_d = id;
         end
      end else if (pulse && !pend_q) begin
         pend_d = 1'b1;
         id_d   = id;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         pend_q <= 1'b0;
         id_q   <= '0;
      end else begin
         pend_q <= pend_d;
         id_q   <= id_d;
      end
   end

   assign pend    = pend_q;
   assign pend_id = id_q;

endmodule

// File: rtl/hit_event_resolver.sv
// Applies captured hit events at each frame boundary: lives, saturating score,
// invulnerability window, game-over/restart and alien kill notification.
module hit_event_resolver
   import hit_event_resolver_pkg::*;
#(
   parameter int unsigned START_LIVES   = DEF_START_LIVES,
   parameter int unsigned LIVES_W       = DEF_LIVES_W,
   parameter int unsigned SCORE_W       = DEF_SCORE_W,
   parameter int unsigned ALIEN_POINTS  = DEF_ALIEN_POINTS,
   parameter int unsigned INVULN_FRAMES = DEF_INVULN_FRAMES,
   parameter int unsigned ID_W          = DEF_ID_W
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               hit_player,
   input  logic               hit_alien,
   input  logic [ID_W-1:0]    hit_alien_id,
   input  logic               restart,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic               invincible,
   output logic               player_blink,
   output logic               game_over,
   output logic               kill_valid,
   output logic [ID_W-1:0]    kill_id
);

   localparam int unsigned INV_W = inv_cnt_width(INVULN_FRAMES);

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
   localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
   localparam logic [INV_W-1:0]   INV_INIT   = INV_W'(INVULN_FRAMES);
   localparam logic [INV_W-1:0]   INV_ONE    = INV_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [SCORE_W:0]   POINTS_EXT = (SCORE_W + 1)'(ALIEN_POINTS);

   hit_state_t         state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [INV_W-1:0]   inv_q, inv_d;
   logic               kill_valid_q, kill_valid_d;
   logic [ID_W-1:0]    kill_id_q, kill_id_d;

   logic               pend_p, pend_a;
   logic [ID_W-1:0]    pend_a_id;
   logic               p_id_unused;
   logic               clr_pend;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_add;

   assign clr_pend = restart && (state_q == GAME_OVER);

   hit_event_resolver_frame_event_latch #(
      .ID_W (1)
   ) u_player_latch (
      .clk     (clk),
      .resetN  (resetN),
      .sof     (startOfFrame),
      .clr     (clr_pend),
      .pulse   (hit_player),
      .id      (1'b0),
      .pend    (pend_p),
      .pend_id (p_id_unused)
   );

   hit_event_resolver_frame_event_latch #(
      .ID_W (ID_W)
   ) u_alien_latch (
      .clk     (clk),
      .resetN  (resetN),
      .sof     (startOfFrame),
      .clr     (clr_pend),
      .pulse   (hit_alien),
      .id      (hit_alien_id),
      .pend    (pend_a),
      .pend_id (pend_a_id)
   );

   // One extra bit catches the carry so the score clamps instead of wrapping.
   assign score_sum = {1'b0, score_q} + POINTS_EXT;
   assign score_add = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      score_d      = score_q;
      inv_d        = inv_q;
      kill_valid_d = 1'b0;
      kill_id_d    = kill_id_q;

      unique case (state_q)
         PLAY: begin
            if (startOfFrame) begin
               if (pend_a) begin
                  score_d      = score_add;
                  kill_valid_d = 1'b1;
                  kill_id_d    = pend_a_id;
               end
               if (pend_p) begin
                  if (lives_q > LIVES_ONE) begin
                     lives_d = lives_q - LIVES_ONE;
                     inv_d   = INV_INIT;
                     state_d = INVULN;
                  end else begin
                     lives_d = '0;
                     state_d = GAME_OVER;
                  end
               end
            end
         end
         INVULN: begin
            if (startOfFrame) begin
               if (pend_a) begin
                  score_d      = score_add;
                  kill_valid_d = 1'b1;
                  kill_id_d    = pend_a_id;
               end
               inv_d = inv_q - INV_ONE;
               if (inv_q == INV_ONE) begin
                  state_d = PLAY;
               end
            end
         end
         GAME_OVER: begin
            if (restart) begin
               lives_d = LIVES_INIT;
               score_d = '0;
               state_d = PLAY;
            end
         end
         default: begin
            state_d = PLAY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q      <= PLAY;
         lives_q      <= LIVES_INIT;
         score_q      <= '0;
         inv_q        <= '0;
         kill_valid_q <= 1'b0;
         kill_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         score_q      <= score_d;
         inv_q        <= inv_d;
         kill_valid_q <= kill_valid_d;
         kill_id_q    <= kill_id_d;
      end
   end

   assign lives        = lives_q;
   assign score        = score_q;
   assign invincible   = (state_q == INVULN);
   assign player_blink = (state_q == INVULN) ? inv_q[2] : 1'b1;
   assign game_over    = (state_q == GAME_OVER);
   assign kill_valid   = kill_valid_q;
   assign kill_id      = kill_id_q;

endmodule

// File: tb/tb_hit_event_resolver.sv
// Directed self-checking bench for hit_event_resolver with default parameters.
module tb_hit_event_resolver;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       hit_player;
   logic       hit_alien;
   logic [5:0] hit_alien_id;
   logic       restart;
   logic [2:0] lives;
   logic [13:0] score;
   logic       invincible;
   logic       player_blink;
   logic       game_over;
   logic       kill_valid;
   logic [5:0] kill_id;

   int n_assert = 0;
   int n_fail   = 0;

   hit_event_resolver dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .hit_player   (hit_player),
      .hit_alien    (hit_alien),
      .hit_alien_id (hit_alien_id),
      .restart      (restart),
      .lives        (lives),
      .score        (score),
      .invincible   (invincible),
      .player_blink (player_blink),
      .game_over    (game_over),
      .kill_valid   (kill_valid),
      .kill_id      (kill_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic alien(input logic [5:0] i);
      hit_alien    = 1'b1;
      hit_alien_id = i;
      step();
      hit_alien    = 1'b0;
   endtask

   task automatic player();
      hit_player = 1'b1;
      step();
      hit_player = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".lives"},  32'(lives), 3);
      chk({tag, ".score"},  32'(score), 0);
      chk({tag, ".inv"},    32'(invincible), 0);
      chk({tag, ".blink"},  32'(player_blink), 1);
      chk({tag, ".go"},     32'(game_over), 0);
      chk({tag, ".kv"},     32'(kill_valid), 0);
      chk({tag, ".kid"},    32'(kill_id), 0);
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      hit_player   = 1'b0;
      hit_alien    = 1'b0;
      hit_alien_id = '0;
      restart      = 1'b0;
      step();
      step();
      check_reset("reset");
      resetN = 1'b1;
      step();

      // Single alien hit, id 5
      alien(6'd5);
      step();
      sof();
      chk("t1.score", 32'(score), 10);
      chk("t1.kv",    32'(kill_valid), 1);
      chk("t1.kid",   32'(kill_id), 5);
      step();
      chk("t1.kv_pulse", 32'(kill_valid), 0);
      chk("t1.kid_hold", 32'(kill_id), 5);

      // Two alien hits in one frame: first id kept, one kill
      alien(6'd3);
      step();
      alien(6'd9);
      sof();
      chk("t2.score", 32'(score), 20);
      chk("t2.kv",    32'(kill_valid), 1);
      chk("t2.kid",   32'(kill_id), 3);
      step();
      sof();
      chk("t2.no_second_kill", 32'(kill_valid), 0);
      chk("t2.score_hold",     32'(score), 20);

      // Restart outside GAME_OVER does nothing
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_ignored.score", 32'(score), 20);
      chk("restart_ignored.lives", 32'(lives), 3);

      // Player hit in PLAY, then 60 frames of invulnerability
      player();
      sof();
      chk("t3.lives", 32'(lives), 2);
      chk("t3.inv",   32'(invincible), 1);
      chk("t3.blink0", 32'(player_blink), 1);
      for (int k = 1; k <= 60; k++) begin
         if (k == 5) player();
         sof();
         if (k == 1)  chk("t3.blink1", 32'(player_blink), 0);
         if (k == 59) chk("t3.inv59", 32'(invincible), 1);
         if (k == 60) chk("t3.inv60", 32'(invincible), 0);
      end
      chk("t3.lives_kept", 32'(lives), 2);
      chk("t3.blink_play", 32'(player_blink), 1);

      // Player hit coincident with SOF lands at the next SOF
      startOfFrame = 1'b1;
      hit_player   = 1'b1;
      step();
      startOfFrame = 1'b0;
      hit_player   = 1'b0;
      chk("t5.lives_same", 32'(lives), 2);
      chk("t5.inv_same",   32'(invincible), 0);
      step();
      sof();
      chk("t5.lives_next", 32'(lives), 1);
      chk("t5.inv_next",   32'(invincible), 1);
      for (int k = 1; k <= 60; k++) sof();
      chk("t5.back_play", 32'(invincible), 0);

      // Last life: player and alien in the same frame
      hit_player   = 1'b1;
      hit_alien    = 1'b1;
      hit_alien_id = 6'd12;
      step();
      hit_player = 1'b0;
      hit_alien  = 1'b0;
      sof();
      chk("t4.lives", 32'(lives), 0);
      chk("t4.score", 32'(score), 30);
      chk("t4.go",    32'(game_over), 1);
      chk("t4.kid",   32'(kill_id), 12);
      step();
      alien(6'd7);
      player();
      sof();
      chk("t4.frozen_lives", 32'(lives), 0);
      chk("t4.frozen_score", 32'(score), 30);
      chk("t4.frozen_kv",    32'(kill_valid), 0);
      chk("t4.frozen_kid",   32'(kill_id), 12);
      alien(6'd8);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("t4.restart_lives", 32'(lives), 3);
      chk("t4.restart_score", 32'(score), 0);
      chk("t4.restart_go",    32'(game_over), 0);
      sof();
      chk("t4.pend_cleared", 32'(kill_valid), 0);
      alien(6'd1);
      sof();
      chk("t4.play_score", 32'(score), 10);

      // Drive score to 16380, then saturate
      for (int k = 0; k < 1637; k++) begin
         alien(6'd2);
         sof();
      end
      chk("t6.score_16380", 32'(score), 16380);
      alien(6'd4);
      sof();
      chk("t6.score_sat", 32'(score), 16383);
      chk("t6.kv_sat",    32'(kill_valid), 1);
      alien(6'd6);
      sof();
      chk("t6.score_hold", 32'(score), 16383);

      // Reset in the middle of INVULN
      player();
      sof();
      sof();
      chk("t6.inv_before_reset", 32'(invincible), 1);
      chk("t6.lives_before_reset", 32'(lives), 2);
      resetN = 1'b0;
      step();
      check_reset("t6.reset");
      resetN = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
